// File: rtl/data_bus_master_if.sv
// Pipeline request/response and data bus signals of the MEM-stage bus initiator.
// The master modport is the initiator view; slave is the pipeline+responder environment.
interface data_bus_master_if;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_error;
    logic [15:0] DataAddr;
    logic [15:0] BusIn;
    logic        ReadData;
    logic        WriteData;
    logic [15:0] BusOut;
    logic        Waitreq;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_error,
        output DataAddr, BusIn, ReadData, WriteData,
        input  BusOut, Waitreq
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_error,
        input  DataAddr, BusIn, ReadData, WriteData,
        output BusOut, Waitreq
    );
endinterface

// File: rtl/data_bus_master.sv
// Data bus initiator: one load/store at a time, holds the strobe through Waitreq,
// returns load data or a store ack, and aborts with an error on a stalled device.
module data_bus_master #(
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    data_bus_master_if.master  bus
);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RLAT} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [15:0]   addr_d, wdata_d, rdata_d;
    logic          rd_d, wr_d, ready_d, rvalid_d, rerr_d;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        lat_d    = lat_q;
        addr_d   = bus.DataAddr;
        wdata_d  = bus.BusIn;
        rd_d     = bus.ReadData;
        wr_d     = bus.WriteData;
        ready_d  = bus.req_ready;
        rdata_d  = bus.resp_data;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rd_d    = !bus.req_write;
                    wr_d    = bus.req_write;
                    ready_d = 1'b0;
                    wait_d  = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Acceptance is tested first so it wins over a same-edge timeout.
                if (!bus.Waitreq) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (bus.WriteData) begin
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        ready_d  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        lat_d   = '0;
                        state_d = RLAT;
                    end
                end else if (TIMEOUT != 0) begin
                    if (wait_q == WW'(TIMEOUT - 1)) begin
                        rd_d     = 1'b0;
                        wr_d     = 1'b0;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        rdata_d  = '0;
                        ready_d  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            RLAT: begin
                if (lat_q == LW'(RD_LATENCY - 1)) begin
                    rdata_d  = bus.BusOut;
                    rvalid_d = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            lat_q          <= '0;
            bus.DataAddr   <= '0;
            bus.BusIn      <= '0;
            bus.ReadData   <= 1'b0;
            bus.WriteData  <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_error <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            lat_q          <= lat_d;
            bus.DataAddr   <= addr_d;
            bus.BusIn      <= wdata_d;
            bus.ReadData   <= rd_d;
            bus.WriteData  <= wr_d;
            bus.req_ready  <= ready_d;
            bus.resp_valid <= rvalid_d;
            bus.resp_data  <= rdata_d;
            bus.resp_error <= rerr_d;
        end
    end
endmodule

// File: tb/tb_data_bus_master.sv
// Directed bench for data_bus_master (RD_LATENCY=1, TIMEOUT=8) with a small
// registered memory responder used for the store-then-load step.
module tb_data_bus_master;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   both_high;

    logic        mem_mode;
    logic [15:0] tb_busout;
    logic [15:0] mem_rdata;
    logic [15:0] mem [0:255];

    data_bus_master_if bus ();

    data_bus_master #(.RD_LATENCY(1), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.BusOut = mem_mode ? mem_rdata : tb_busout;

    // Registered memory: writes land on acceptance, read data is valid one edge after acceptance.
    always @(posedge clk) begin
        if (bus.WriteData && !bus.Waitreq) mem[bus.DataAddr[7:0]] <= bus.BusIn;
        if (bus.ReadData && !bus.Waitreq) mem_rdata <= mem[bus.DataAddr[7:0]];
    end

    always @(negedge clk) begin
        if (bus.ReadData && bus.WriteData) both_high++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        both_high   = 0;
        rst         = 1'b1;
        mem_mode    = 1'b0;
        tb_busout   = 16'h0000;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;
        bus.Waitreq   = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", 16'(bus.req_ready), 16'd1);
        check("rst_resp_valid", 16'(bus.resp_valid), 16'd0);
        check("rst_resp_data", bus.resp_data, 16'h0000);
        check("rst_resp_error", 16'(bus.resp_error), 16'd0);
        check("rst_strobes", {14'd0, bus.ReadData, bus.WriteData}, 16'd0);
        check("rst_addr", bus.DataAddr, 16'h0000);
        check("rst_busin", bus.BusIn, 16'h0000);
        step();
        step();
        rst = 1'b0;
        step();

        // Load 0x0123, no wait states, BEEF in the latency cycle
        request(1'b0, 16'h0123, 16'h0000);
        step();
        check("ld_rd_strobe", 16'(bus.ReadData), 16'd1);
        check("ld_wr_strobe", 16'(bus.WriteData), 16'd0);
        check("ld_addr", bus.DataAddr, 16'h0123);
        check("ld_ready_low", 16'(bus.req_ready), 16'd0);
        bus.req_valid = 1'b0;
        step();
        check("ld_rd_one_cycle", 16'(bus.ReadData), 16'd0);
        check("ld_no_early_resp", 16'(bus.resp_valid), 16'd0);
        tb_busout = 16'hBEEF;
        step();
        check("ld_resp_valid", 16'(bus.resp_valid), 16'd1);
        check("ld_resp_data", bus.resp_data, 16'hBEEF);
        check("ld_resp_error", 16'(bus.resp_error), 16'd0);
        check("ld_ready_back", 16'(bus.req_ready), 16'd1);
        tb_busout = 16'h0000;
        step();
        check("ld_resp_pulse", 16'(bus.resp_valid), 16'd0);

        // Timeout: load 0x1000 with Waitreq stuck high
        bus.Waitreq = 1'b1;
        request(1'b0, 16'h1000, 16'h0000);
        step();
        bus.req_valid = 1'b0;
        check("to_rd_strobe", 16'(bus.ReadData), 16'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("to_hold_%0d", i), {14'd0, bus.ReadData, bus.resp_valid}, 16'b10);
        end
        step();
        check("to_strobe_drop", 16'(bus.ReadData), 16'd0);
        check("to_resp_valid", 16'(bus.resp_valid), 16'd1);
        check("to_resp_error", 16'(bus.resp_error), 16'd1);
        check("to_resp_data", bus.resp_data, 16'h0000);
        bus.Waitreq = 1'b1;
        step();
        check("to_resp_pulse", {14'd0, bus.resp_valid, bus.resp_error}, 16'd0);

        // Store 0x0042 <= 0x5A5A with three wait cycles, accepted right after the timeout
        request(1'b1, 16'h0042, 16'h5A5A);
        step();
        check("st_wr_strobe", 16'(bus.WriteData), 16'd1);
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'hFFFF;
        bus.req_wdata = 16'hFFFF;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("st_wait_strobe_%0d", i), {14'd0, bus.WriteData, bus.ReadData}, 16'b10);
            check($sformatf("st_wait_addr_%0d", i), bus.DataAddr, 16'h0042);
            check($sformatf("st_wait_busin_%0d", i), bus.BusIn, 16'h5A5A);
            check($sformatf("st_wait_flags_%0d", i), {14'd0, bus.req_ready, bus.resp_valid}, 16'd0);
        end
        bus.Waitreq = 1'b0;
        step();
        check("st_strobe_drop", 16'(bus.WriteData), 16'd0);
        check("st_resp_valid", 16'(bus.resp_valid), 16'd1);
        check("st_resp_data", bus.resp_data, 16'h0000);
        check("st_resp_error", 16'(bus.resp_error), 16'd0);
        step();

        // Waitreq releases on the exact timeout edge: normal load completion
        bus.Waitreq = 1'b1;
        request(1'b0, 16'h2000, 16'h0000);
        step();
        bus.req_valid = 1'b0;
        for (int i = 1; i < 8; i++) step();
        check("edge_still_waiting", {14'd0, bus.ReadData, bus.resp_valid}, 16'b10);
        bus.Waitreq = 1'b0;
        step();
        check("edge_accept", {14'd0, bus.ReadData, bus.resp_valid}, 16'b00);
        tb_busout = 16'h7777;
        step();
        check("edge_resp_valid", 16'(bus.resp_valid), 16'd1);
        check("edge_resp_error", 16'(bus.resp_error), 16'd0);
        check("edge_resp_data", bus.resp_data, 16'h7777);
        step();

        // Reset in the middle of a stalled store
        bus.Waitreq = 1'b1;
        request(1'b1, 16'h0300, 16'hAAAA);
        step();
        bus.req_valid = 1'b0;
        step();
        check("mid_strobe_before", 16'(bus.WriteData), 16'd1);
        rst = 1'b1;
        #1;
        check("mid_strobes_async", {14'd0, bus.ReadData, bus.WriteData}, 16'd0);
        check("mid_no_resp", 16'(bus.resp_valid), 16'd0);
        check("mid_ready", 16'(bus.req_ready), 16'd1);
        check("mid_addr", bus.DataAddr, 16'h0000);
        step();
        rst = 1'b0;
        bus.Waitreq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_after_%0d", i),
                  {13'd0, bus.req_ready, bus.resp_valid, bus.WriteData}, 16'b100);
        end

        // Store 0x0010 <= 0x1234, then a load issued in the resp_valid cycle
        mem_mode = 1'b1;
        request(1'b1, 16'h0010, 16'h1234);
        step();
        check("b2b_wr_strobe", 16'(bus.WriteData), 16'd1);
        request(1'b0, 16'h0010, 16'h0000);
        step();
        check("b2b_st_resp", {13'd0, bus.resp_valid, bus.req_ready, bus.ReadData}, 16'b110);
        step();
        bus.req_valid = 1'b0;
        check("b2b_ld_accept", {13'd0, bus.ReadData, bus.WriteData, bus.resp_valid}, 16'b100);
        check("b2b_ld_addr", bus.DataAddr, 16'h0010);
        step();
        check("b2b_ld_wait", 16'(bus.resp_valid), 16'd0);
        step();
        check("b2b_ld_resp", 16'(bus.resp_valid), 16'd1);
        check("b2b_ld_data", bus.resp_data, 16'h1234);
        step();
        check("no_dual_strobe", 16'(both_high), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
